// File: rtl/hea_func_pack.sv
// Shared HEA datapath types and GF(2^8) multiply-by-constant helpers (AES polynomial 0x11B).
package hea_func_pack;

   typedef logic [127:0] hea_state_t;
   typedef logic [31:0]  hea_col_t;

   typedef enum logic {
      HEA_MC_FWD = 1'b0,
      HEA_MC_INV = 1'b1
   } hea_mc_mode_e;

   typedef enum logic [1:0] {
      HEA_MC_IDLE = 2'd0,
      HEA_MC_BUSY = 2'd1,
      HEA_MC_DONE = 2'd2
   } hea_mc_fsm_e;

   localparam int HEA_NUM_COLS = 4;

   function automatic logic [7:0] gfmul2(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gfmul3(input logic [7:0] a);
      return gfmul2(a) ^ a;
   endfunction

   // The inverse coefficients are built from the x2/x4/x8 ladder of the input byte.
   function automatic logic [7:0] gfmul9(input logic [7:0] a);
      return gfmul2(gfmul2(gfmul2(a))) ^ a;
   endfunction

   function automatic logic [7:0] gfmul11(input logic [7:0] a);
      return gfmul2(gfmul2(gfmul2(a))) ^ gfmul2(a) ^ a;
   endfunction

   function automatic logic [7:0] gfmul13(input logic [7:0] a);
      return gfmul2(gfmul2(gfmul2(a))) ^ gfmul2(gfmul2(a)) ^ a;
   endfunction

   function automatic logic [7:0] gfmul14(input logic [7:0] a);
      return gfmul2(gfmul2(gfmul2(a))) ^ gfmul2(gfmul2(a)) ^ gfmul2(a);
   endfunction

endpackage

// File: rtl/hea_mixcol_col.sv
// Combinational single-column MixColumns / InvMixColumns; row 0 is the column's top byte.
module hea_mixcol_col
   import hea_func_pack::*;
(
   input  logic [31:0] col_in,
   input  logic        mode,
   output logic [31:0] col_out
);

   logic [7:0] a0, a1, a2, a3;

   assign a0 = col_in[31:24];
   assign a1 = col_in[23:16];
   assign a2 = col_in[15:8];
   assign a3 = col_in[7:0];

   // Every output row uses the same circulant coefficients, applied to a rotated column.
   function automatic logic [7:0] mix_row(input logic [7:0] r0, input logic [7:0] r1,
                                          input logic [7:0] r2, input logic [7:0] r3,
                                          input logic       inv);
      if (inv)
         return gfmul14(r0) ^ gfmul11(r1) ^ gfmul13(r2) ^ gfmul9(r3);
      else
         return gfmul2(r0) ^ gfmul3(r1) ^ r2 ^ r3;
   endfunction

   assign col_out = {mix_row(a0, a1, a2, a3, mode),
                     mix_row(a1, a2, a3, a0, mode),
                     mix_row(a2, a3, a0, a1, mode),
                     mix_row(a3, a0, a1, a2, mode)};

endmodule

// File: rtl/hea_mixcol_engine.sv
// Iterative MixColumns / InvMixColumns engine: accepts a state, mixes COLS_PER_CYCLE columns
// per clock in place, then holds the result until the consumer takes it.
module hea_mixcol_engine
   import hea_func_pack::*;
#(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_inv,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("hea_mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   // Counter step wraps to 0 when all four columns go in one cycle, which keeps col_cnt at 0.
   localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] CNT_LAST = 2'(HEA_NUM_COLS - COLS_PER_CYCLE);

   hea_mc_fsm_e  state;
   logic [1:0]   col_cnt;
   hea_state_t   work;
   hea_state_t   work_nxt;
   logic         mode;

   logic [1:0]   col_idx [COLS_PER_CYCLE];
   hea_col_t     col_src [COLS_PER_CYCLE];
   hea_col_t     col_mix [COLS_PER_CYCLE];

   assign in_ready  = (state == HEA_MC_IDLE) || ((state == HEA_MC_DONE) && out_ready);
   assign out_state = work;

   // Column c lives at bits [127-32c -: 32], i.e. word index 3-c, which is ~c for a 2-bit c.
   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
      assign col_idx[g] = col_cnt + 2'(g);
      assign col_src[g] = work[{~col_idx[g], 5'd0} +: 32];

      hea_mixcol_col u_col (
         .col_in  (col_src[g]),
         .mode    (mode),
         .col_out (col_mix[g])
      );
   end

   always_comb begin
      work_nxt = work;
      for (int i = 0; i < COLS_PER_CYCLE; i++) begin
         work_nxt[{~col_idx[i], 5'd0} +: 32] = col_mix[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= HEA_MC_IDLE;
         col_cnt   <= 2'd0;
         work      <= '0;
         mode      <= HEA_MC_FWD;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            HEA_MC_IDLE: begin
               if (in_valid) begin
                  state   <= HEA_MC_BUSY;
                  work    <= in_state;
                  mode    <= in_inv;
                  col_cnt <= 2'd0;
                  busy    <= 1'b1;
               end
            end
            HEA_MC_BUSY: begin
               work    <= work_nxt;
               col_cnt <= col_cnt + CNT_STEP;
               if (col_cnt == CNT_LAST) begin
                  state     <= HEA_MC_DONE;
                  out_valid <= 1'b1;
               end
            end
            HEA_MC_DONE: begin
               // The handoff edge can accept the next state directly, hiding the DONE cycle.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     state   <= HEA_MC_BUSY;
                     work    <= in_state;
                     mode    <= in_inv;
                     col_cnt <= 2'd0;
                  end else begin
                     state <= HEA_MC_IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= HEA_MC_IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hea_mixcol_engine.sv
// Directed bench for hea_mixcol_engine with instances at 1, 2 and 4 columns per cycle.
module tb_hea_mixcol_engine;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [2:0]   iv, ii, ordy;
   logic [2:0]   irdy, ovl, bsy;
   logic [127:0] ist [3];
   logic [127:0] ost0, ost1, ost2;

   int vectors = 0;
   int miscompares = 0;

   localparam logic [127:0] V1     = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] V1OUT  = 128'h046681e5e0cb199a48f8d37a2806264c;
   localparam logic [127:0] VCOL   = 128'hdb135345f20a225c01010101c6c6c6c6;
   localparam logic [127:0] VCOLMX = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;

   always #5 clk = ~clk;

   hea_mixcol_engine #(.COLS_PER_CYCLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]), .in_inv(ii[0]),
      .in_state(ist[0]), .out_valid(ovl[0]), .out_ready(ordy[0]), .out_state(ost0), .busy(bsy[0]));
   hea_mixcol_engine #(.COLS_PER_CYCLE(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]), .in_inv(ii[1]),
      .in_state(ist[1]), .out_valid(ovl[1]), .out_ready(ordy[1]), .out_state(ost1), .busy(bsy[1]));
   hea_mixcol_engine #(.COLS_PER_CYCLE(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]), .in_inv(ii[2]),
      .in_state(ist[2]), .out_valid(ovl[2]), .out_ready(ordy[2]), .out_state(ost2), .busy(bsy[2]));

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [127:0] get_ost(input int d);
      case (d)
         0:       return ost0;
         1:       return ost1;
         default: return ost2;
      endcase
   endfunction

   // Reference: generic shift-and-add GF(2^8) product and the full coefficient matrix.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
      logic [7:0]   k [4];
      logic [7:0]   a [4];
      logic [7:0]   b;
      logic [127:0] r;
      if (inv) begin
         k[0] = 8'd14; k[1] = 8'd11; k[2] = 8'd13; k[3] = 8'd9;
      end else begin
         k[0] = 8'd2;  k[1] = 8'd3;  k[2] = 8'd1;  k[3] = 8'd1;
      end
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
         for (int row = 0; row < 4; row++) begin
            b = 8'h00;
            for (int j = 0; j < 4; j++) b = b ^ gmul(k[j], a[(row + j) % 4]);
            r[127 - 32*c - 8*row -: 8] = b;
         end
      end
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one state, wait for accept, then count edges until out_valid rises (result held).
   task automatic xact(input int d, input logic [127:0] s, input logic inv,
                       output logic [127:0] res, output int lat);
      int n;
      iv[d] = 1'b1;
      ist[d] = s;
      ii[d] = inv;
      n = 0;
      while (!irdy[d] && n < 50) begin
         step();
         n++;
      end
      chk("in_ready_before_accept", {127'd0, irdy[d]}, 128'd1);
      step();
      iv[d] = 1'b0;
      lat = 0;
      while (!ovl[d] && lat < 50) begin
         step();
         lat++;
      end
      res = get_ost(d);
   endtask

   task automatic pop(input int d);
      ordy[d] = 1'b1;
      step();
      ordy[d] = 1'b0;
   endtask

   initial begin
      logic [127:0] res, res2, s;
      logic [127:0] bs [3];
      logic         bm [3];
      logic [127:0] be [3];
      int           lat, n, d;

      iv = '0; ii = '0; ordy = '0;
      for (int i = 0; i < 3; i++) ist[i] = '0;
      step();
      step();
      chk("rst_out_valid", {125'd0, ovl}, 128'd0);
      chk("rst_busy", {125'd0, bsy}, 128'd0);
      chk("rst_in_ready", {125'd0, irdy}, 128'd7);
      chk("rst_out_state", ost0, 128'd0);
      rst_n = 1'b1;
      step();

      // Known-answer vectors on every instance; latency is 4/C edges.
      for (int k = 0; k < 3; k++) begin
         xact(k, V1, 1'b0, res, lat);
         chk("fips_fwd", res, V1OUT);
         chk("fips_fwd_latency", 128'(lat), 128'(4 >> k));
         pop(k);
         xact(k, V1OUT, 1'b1, res, lat);
         chk("fips_inv", res, V1);
         chk("fips_inv_latency", 128'(lat), 128'(4 >> k));
         pop(k);
         xact(k, VCOL, 1'b0, res, lat);
         chk("col_fwd", res, VCOLMX);
         pop(k);
         xact(k, VCOLMX, 1'b1, res, lat);
         chk("col_inv", res, VCOL);
         pop(k);
         chk("idle_after_pop", {126'd0, irdy[k], bsy[k]}, 128'd2);
      end

      // Backpressure, with input changes and a stray in_valid during BUSY.
      iv[0] = 1'b1; ist[0] = V1; ii[0] = 1'b0;
      step();
      ist[0] = ~V1; ii[0] = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("bp_valid_rise", {127'd0, ovl[0]}, 128'd1);
      chk("bp_result", ost0, V1OUT);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_hold_valid", {126'd0, ovl[0], bsy[0]}, 128'd3);
         chk("bp_hold_state", ost0, V1OUT);
         chk("bp_in_ready_low", {127'd0, irdy[0]}, 128'd0);
      end
      iv[0] = 1'b0;
      pop(0);
      chk("bp_released", {125'd0, ovl[0], bsy[0], irdy[0]}, 128'd1);

      // Back-to-back with out_ready tied high and mixed modes.
      bs[0] = V1;     bm[0] = 1'b0; be[0] = V1OUT;
      bs[1] = V1OUT;  bm[1] = 1'b1; be[1] = V1;
      bs[2] = VCOL;   bm[2] = 1'b0; be[2] = VCOLMX;
      ordy[0] = 1'b1; iv[0] = 1'b1; ist[0] = bs[0]; ii[0] = bm[0];
      step();
      for (int k = 0; k < 3; k++) begin
         if (k < 2) begin
            ist[0] = bs[k+1];
            ii[0]  = bm[k+1];
         end else begin
            iv[0] = 1'b0;
         end
         n = 0;
         while (!ovl[0] && n < 20) begin
            step();
            n++;
         end
         chk("b2b_latency", 128'(n), 128'd4);
         chk("b2b_result", ost0, be[k]);
         chk("b2b_in_ready_done", {127'd0, irdy[0]}, 128'd1);
         step();
      end
      ordy[0] = 1'b0;
      chk("b2b_end_idle", {126'd0, ovl[0], bsy[0]}, 128'd0);

      // Asynchronous reset during the second BUSY cycle drops the transaction.
      iv[0] = 1'b1; ist[0] = V1; ii[0] = 1'b0;
      step();
      iv[0] = 1'b0;
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", {127'd0, ovl[0]}, 128'd0);
      chk("arst_busy", {127'd0, bsy[0]}, 128'd0);
      chk("arst_in_ready", {127'd0, irdy[0]}, 128'd1);
      chk("arst_out_state", ost0, 128'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("arst_no_pulse", {127'd0, ovl[0]}, 128'd0);
      xact(0, V1, 1'b0, res, lat);
      chk("arst_next_result", res, V1OUT);
      chk("arst_next_latency", 128'(lat), 128'd4);
      pop(0);

      // Random round trips on the wider instances against the bench model.
      for (int i = 0; i < 1000; i++) begin
         d = 1 + (i % 2);
         s = {$urandom, $urandom, $urandom, $urandom};
         xact(d, s, 1'b0, res, lat);
         pop(d);
         chk("rand_fwd", res, model(s, 1'b0));
         xact(d, res, 1'b1, res2, lat);
         pop(d);
         chk("rand_roundtrip", res2, s);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
